// File: rtl/io_terminal_port.sv
// io_terminal_port: device side of the programmed-I/O terminal.
// Holds INPR/OUTR/FGI/FGO and handshakes with keyboard and printer.
module io_terminal_port #(
   parameter int DATA_W    = 8,
   parameter int PRN_DELAY = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [15:0]       bus_in,
   input  logic              ld_outr,
   input  logic              reset_fgi,
   input  logic              reset_fgo,
   input  logic [DATA_W-1:0] kbd_data,
   input  logic              kbd_valid,
   output logic              kbd_ready,
   output logic [DATA_W-1:0] prn_data,
   output logic              prn_valid,
   input  logic              prn_ready,
   output logic [DATA_W-1:0] inpr,
   output logic              fgi,
   output logic              fgo,
   output logic              ovr_err
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SEND = 2'd1;
   localparam logic [1:0] S_BUSY = 2'd2;

   localparam logic [7:0] C_LOAD = 8'(PRN_DELAY - 1);

   logic [DATA_W-1:0] r_inpr;
   logic              r_fgi;
   logic [DATA_W-1:0] r_outr;
   logic              r_fgo;
   logic              r_ovr;
   logic [1:0]        r_state;
   logic [7:0]        r_cnt;

   logic w_kbd_hs;
   logic w_idle;
   logic w_ld_ok;
   logic w_done;
   logic w_unused_bus;

   assign w_kbd_hs     = kbd_valid & ~r_fgi;
   assign w_idle       = (r_state == S_IDLE);
   assign w_ld_ok      = ld_outr & w_idle & r_fgo;
   assign w_done       = (r_state == S_BUSY) & (r_cnt == 8'd0);
   assign w_unused_bus = ^bus_in[15:DATA_W];

   assign kbd_ready = ~r_fgi;
   assign prn_valid = (r_state == S_SEND);
   assign prn_data  = r_outr;
   assign inpr      = r_inpr;
   assign fgi       = r_fgi;
   assign fgo       = r_fgo;
   assign ovr_err   = r_ovr;

   // Keyboard side: capture a character and raise FGI; INP clears FGI.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_inpr <= '0;
         r_fgi  <= 1'b0;
      end else if (w_kbd_hs) begin
         r_inpr <= kbd_data;
         r_fgi  <= 1'b1;
      end else if (reset_fgi) begin
         r_fgi <= 1'b0;
      end
   end

   // Printer side: offer OUTR, then count printer latency before idling.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_outr  <= '0;
         r_cnt   <= 8'd0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_ld_ok) begin
                  r_outr  <= bus_in[DATA_W-1:0];
                  r_state <= S_SEND;
               end
            end
            S_SEND: begin
               if (prn_ready) begin
                  r_cnt   <= C_LOAD;
                  r_state <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (r_cnt == 8'd0) begin
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt - 8'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // FGO: printer completion sets it and beats a coincident clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_fgo <= 1'b1;
      end else if (w_done) begin
         r_fgo <= 1'b1;
      end else if (reset_fgo) begin
         r_fgo <= 1'b0;
      end
   end

   // Sticky error: OUTR load while not ready, or clear racing completion.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ovr <= 1'b0;
      end else if ((ld_outr & ~w_ld_ok) | (w_done & reset_fgo)) begin
         r_ovr <= 1'b1;
      end
   end

endmodule

// File: tb/tb_io_terminal_port.sv
// tb_io_terminal_port: directed scenarios plus randomized run
// checked against a transaction-level model of the terminal port.
module tb_io_terminal_port;

   localparam int DW = 8;
   localparam int PD = 4;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [15:0]   bus_in = '0;
   logic          ld_outr = 1'b0;
   logic          reset_fgi = 1'b0;
   logic          reset_fgo = 1'b0;
   logic [DW-1:0] kbd_data = '0;
   logic          kbd_valid = 1'b0;
   logic          kbd_ready;
   logic [DW-1:0] prn_data;
   logic          prn_valid;
   logic          prn_ready = 1'b0;
   logic [DW-1:0] inpr;
   logic          fgi;
   logic          fgo;
   logic          ovr_err;

   int passed = 0;
   int total  = 0;

   // reference model state
   int          cyc = 0;
   bit          m_fgi, m_fgo, m_ovr, m_pend;
   logic [7:0]  m_inpr, m_outr;
   int          m_done_at = -1;

   always #5 clk = ~clk;

   io_terminal_port #(.DATA_W(DW), .PRN_DELAY(PD)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus_in    (bus_in),
      .ld_outr   (ld_outr),
      .reset_fgi (reset_fgi),
      .reset_fgo (reset_fgo),
      .kbd_data  (kbd_data),
      .kbd_valid (kbd_valid),
      .kbd_ready (kbd_ready),
      .prn_data  (prn_data),
      .prn_valid (prn_valid),
      .prn_ready (prn_ready),
      .inpr      (inpr),
      .fgi       (fgi),
      .fgo       (fgo),
      .ovr_err   (ovr_err)
   );

   // Model: a character waits for the printer, then fgo returns
   // PRN_DELAY edges after the accept edge.
   task automatic model_edge();
      bit idle;
      bit complete;
      bit pend0;
      if (rst) begin
         m_fgi = 0; m_inpr = '0; m_fgo = 1; m_ovr = 0;
         m_outr = '0; m_pend = 0; m_done_at = -1;
      end else begin
         idle     = !m_pend && (m_done_at < 0);
         complete = (m_done_at == cyc);
         pend0    = m_pend;
         if (kbd_valid && !m_fgi) begin
            m_inpr = kbd_data;
            m_fgi  = 1;
         end else if (reset_fgi) begin
            m_fgi = 0;
         end
         if (pend0 && prn_ready) begin
            m_pend    = 0;
            m_done_at = cyc + PD;
         end
         if (ld_outr) begin
            if (idle && m_fgo) begin
               m_outr = bus_in[7:0];
               m_pend = 1;
            end else begin
               m_ovr = 1;
            end
         end
         if (complete) begin
            m_fgo     = 1;
            m_done_at = -1;
            if (reset_fgo) m_ovr = 1;
         end else if (reset_fgo) begin
            m_fgo = 0;
         end
      end
      cyc++;
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();
      total++;
      if (fgi !== 1'b0) $display("FAIL reset_fgi: got %b want 0", fgi);
      else passed++;
      total++;
      if (fgo !== 1'b1) $display("FAIL reset_fgo: got %b want 1", fgo);
      else passed++;
      total++;
      if (kbd_ready !== 1'b1) $display("FAIL reset_kbd_ready: got %b want 1", kbd_ready);
      else passed++;
      total++;
      if (prn_valid !== 1'b0) $display("FAIL reset_prn_valid: got %b want 0", prn_valid);
      else passed++;
      total++;
      if (inpr !== 8'h00) $display("FAIL reset_inpr: got %h want 00", inpr);
      else passed++;
      total++;
      if (ovr_err !== 1'b0) $display("FAIL reset_ovr: got %b want 0", ovr_err);
      else passed++;
   endtask

   task automatic test_keyboard();
      kbd_data  = 8'h41;
      kbd_valid = 1'b1;
      step();
      kbd_valid = 1'b0;
      total++;
      if ({inpr, fgi, kbd_ready} !== {8'h41, 1'b1, 1'b0})
         $display("FAIL kbd_capture: got inpr=%h fgi=%b rdy=%b want 41 1 0",
                  inpr, fgi, kbd_ready);
      else passed++;
      kbd_data  = 8'h99;
      kbd_valid = 1'b1;
      step();
      kbd_valid = 1'b0;
      total++;
      if ({inpr, fgi} !== {8'h41, 1'b1})
         $display("FAIL kbd_blocked: got inpr=%h fgi=%b want 41 1", inpr, fgi);
      else passed++;
      reset_fgi = 1'b1;
      step();
      reset_fgi = 1'b0;
      total++;
      if ({inpr, fgi, kbd_ready} !== {8'h41, 1'b0, 1'b1})
         $display("FAIL kbd_clear: got inpr=%h fgi=%b rdy=%b want 41 0 1",
                  inpr, fgi, kbd_ready);
      else passed++;
   endtask

   task automatic test_print();
      int n;
      bus_in    = 16'h1F5A;
      ld_outr   = 1'b1;
      reset_fgo = 1'b1;
      prn_ready = 1'b1;
      step();
      ld_outr   = 1'b0;
      reset_fgo = 1'b0;
      total++;
      if ({fgo, prn_valid, prn_data} !== {1'b0, 1'b1, 8'h5A})
         $display("FAIL print_offer: got fgo=%b v=%b d=%h want 0 1 5a",
                  fgo, prn_valid, prn_data);
      else passed++;
      step();
      total++;
      if ({fgo, prn_valid} !== {1'b0, 1'b0})
         $display("FAIL print_accept: got fgo=%b v=%b want 0 0", fgo, prn_valid);
      else passed++;
      n = 0;
      while (fgo !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      total++;
      if (n !== PD) $display("FAIL print_latency: got %0d want %0d", n, PD);
      else passed++;
      prn_ready = 1'b0;
   endtask

   task automatic test_stall();
      int n;
      int bad;
      bus_in    = 16'h1F5A;
      ld_outr   = 1'b1;
      reset_fgo = 1'b1;
      prn_ready = 1'b0;
      step();
      ld_outr   = 1'b0;
      reset_fgo = 1'b0;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if ({prn_valid, prn_data, fgo} !== {1'b1, 8'h5A, 1'b0}) bad++;
      end
      total++;
      if (bad !== 0)
         $display("FAIL stall_hold: got %0d bad cycles want 0", bad);
      else passed++;
      prn_ready = 1'b1;
      step();
      total++;
      if (prn_valid !== 1'b0)
         $display("FAIL stall_accept: got v=%b want 0", prn_valid);
      else passed++;
      n = 0;
      while (fgo !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      total++;
      if (n !== PD) $display("FAIL stall_latency: got %0d want %0d", n, PD);
      else passed++;
      prn_ready = 1'b0;
   endtask

   task automatic test_overrun();
      int n;
      bus_in    = 16'h1F5A;
      ld_outr   = 1'b1;
      reset_fgo = 1'b1;
      prn_ready = 1'b1;
      step();
      ld_outr   = 1'b0;
      reset_fgo = 1'b0;
      step();
      bus_in  = 16'h0033;
      ld_outr = 1'b1;
      step();
      ld_outr = 1'b0;
      n = 1;
      total++;
      if ({ovr_err, prn_data, prn_valid} !== {1'b1, 8'h5A, 1'b0})
         $display("FAIL ovr_set: got ovr=%b d=%h v=%b want 1 5a 0",
                  ovr_err, prn_data, prn_valid);
      else passed++;
      while (fgo !== 1'b1 && n < 20) begin
         step();
         n++;
      end
      total++;
      if (n !== PD) $display("FAIL ovr_latency: got %0d want %0d", n, PD);
      else passed++;
      step();
      total++;
      if ({ovr_err, prn_data, prn_valid} !== {1'b1, 8'h5A, 1'b0})
         $display("FAIL ovr_sticky: got ovr=%b d=%h v=%b want 1 5a 0",
                  ovr_err, prn_data, prn_valid);
      else passed++;
      prn_ready = 1'b0;
   endtask

   task automatic test_rst_mid();
      bus_in    = 16'h00A7;
      ld_outr   = 1'b1;
      reset_fgo = 1'b1;
      prn_ready = 1'b0;
      step();
      ld_outr   = 1'b0;
      reset_fgo = 1'b0;
      total++;
      if (prn_valid !== 1'b1) $display("FAIL rst_send: got v=%b want 1", prn_valid);
      else passed++;
      rst       = 1'b1;
      kbd_data  = 8'h3C;
      kbd_valid = 1'b1;
      step();
      total++;
      if ({prn_valid, fgo, fgi, inpr, ovr_err} !==
          {1'b0, 1'b1, 1'b0, 8'h00, 1'b0})
         $display("FAIL rst_mid: got v=%b fgo=%b fgi=%b inpr=%h ovr=%b want 0 1 0 00 0",
                  prn_valid, fgo, fgi, inpr, ovr_err);
      else passed++;
      rst = 1'b0;
      step();
      kbd_valid = 1'b0;
      total++;
      if ({fgi, inpr} !== {1'b1, 8'h3C})
         $display("FAIL rst_kbd_after: got fgi=%b inpr=%h want 1 3c", fgi, inpr);
      else passed++;
   endtask

   task automatic test_random();
      logic [20:0] got, exp;
      int shown;
      shown = 0;
      for (int i = 0; i < 3000; i++) begin
         rst       = ($urandom_range(0, 99) == 0);
         kbd_valid = $urandom_range(0, 1) == 1;
         kbd_data  = 8'($urandom);
         reset_fgi = ($urandom_range(0, 3) == 0);
         ld_outr   = ($urandom_range(0, 7) == 0);
         if (ld_outr) reset_fgo = ($urandom_range(0, 7) != 0);
         else         reset_fgo = ($urandom_range(0, 31) == 0);
         bus_in    = 16'($urandom);
         prn_ready = $urandom_range(0, 1) == 1;
         step();
         got = {fgi, fgo, kbd_ready, prn_valid, prn_data, inpr, ovr_err};
         exp = {m_fgi, m_fgo, !m_fgi, m_pend, m_outr, m_inpr, m_ovr};
         total++;
         if (got !== exp) begin
            if (shown < 10)
               $display("FAIL random cyc %0d: got %h want %h", i, got, exp);
            shown++;
         end else passed++;
      end
      rst = 1'b0; ld_outr = 1'b0; reset_fgo = 1'b0;
      reset_fgi = 1'b0; kbd_valid = 1'b0; prn_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_keyboard();
      test_print();
      test_stall();
      test_overrun();
      test_rst_mid();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
